nibble_serial_sub: RTL

Multi-cycle WIDTH-bit subtractor/comparator that computes A − B one 4-bit group per clock. Each group is a two's-complement add of A and ~B, with the group carries produced by 4-bit lookahead equations. The carry between groups is held in a register. It sits beside the combinational add/sub datapath of the ALU as its area-cheap counterpart. It adds a borrow-based comparison path that returns difference, borrow and signed/unsigned compare flags over a valid/ready handshake.

---
 rtl/nibble_serial_sub.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor/comparator: computes a - b one 4-bit group per clock
// using 4-bit carry-lookahead groups chained through a carry register.
module nibble_serial_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             lt_s,
    output logic             lt_u
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_areg;
    logic [WIDTH-1:0] r_breg;
    logic             r_c;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_diff;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;
    logic             r_lt_s;
    logic             r_lt_u;

    logic [3:0]       w_ga;
    logic [3:0]       w_gb;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [3:0]       w_carry;
    logic             w_cout;
    logic [3:0]       w_sum;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_ovf_nxt;
    logic             w_neg_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_k == KW'(N - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Current group: generate/propagate and 4-bit lookahead carries
    always_comb begin
        w_ga       = r_areg[{r_k, 2'b00} +: 4];
        w_gb       = r_breg[{r_k, 2'b00} +: 4];
        w_g        = w_ga & w_gb;
        w_p        = w_ga ^ w_gb;
        w_carry[0] = r_c;
        w_carry[1] = w_g[0] | (w_p[0] & r_c);
        w_carry[2] = w_g[1] | (w_g[0] & w_p[1]) | (r_c & w_p[0] & w_p[1]);
        w_carry[3] = w_g[2] | (w_g[1] & w_p[2]) | (w_g[0] & w_p[1] & w_p[2])
                   | (r_c & w_p[0] & w_p[1] & w_p[2]);
        w_cout     = w_g[3] | (w_g[2] & w_p[3]) | (w_g[1] & w_p[2] & w_p[3])
                   | (w_g[0] & w_p[1] & w_p[2] & w_p[3])
                   | (r_c & w_p[0] & w_p[1] & w_p[2] & w_p[3]);
        w_sum      = w_p ^ w_carry;
        w_diff_nxt = r_diff;
        w_diff_nxt[{r_k, 2'b00} +: 4] = w_sum;
        // On the last group, carry[3] is the carry into the MSB
        w_ovf_nxt  = w_carry[3] ^ w_cout;
        w_neg_nxt  = w_diff_nxt[WIDTH-1];
    end

    // Datapath, result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_areg      <= '0;
            r_breg      <= '0;
            r_c         <= 1'b0;
            r_k         <= '0;
            r_diff      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_borrow    <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_lt_s      <= 1'b0;
            r_lt_u      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_areg   <= a;
                r_breg   <= ~b;
                r_c      <= 1'b1;
                r_k      <= '0;
                r_diff   <= '0;
                r_borrow <= 1'b0;
                r_ovf    <= 1'b0;
                r_zero   <= 1'b0;
                r_neg    <= 1'b0;
                r_lt_s   <= 1'b0;
                r_lt_u   <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_diff <= w_diff_nxt;
                r_c    <= w_cout;
                r_k    <= r_k + KW'(1);
                if (w_last) begin
                    r_borrow <= ~w_cout;
                    r_lt_u   <= ~w_cout;
                    r_ovf    <= w_ovf_nxt;
                    r_zero   <= (w_diff_nxt == '0);
                    r_neg    <= w_neg_nxt;
                    r_lt_s   <= w_neg_nxt ^ w_ovf_nxt;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign lt_s      = r_lt_s;
    assign lt_u      = r_lt_u;

endmodule
